// File: rtl/sensor_sched_pkg.sv
// Shared codes and FSM encoding for the DHT11 request scheduler.
package sensor_sched_pkg;

    localparam logic [1:0] REQ_HUM  = 2'b00;
    localparam logic [1:0] REQ_TEMP = 2'b01;
    localparam logic [1:0] REQ_STAT = 2'b10;
    localparam logic [1:0] REQ_IDLE = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } sched_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sched_down_timer.sv
// Loadable down-counter that saturates at zero; expired is high while the count is zero.
module sched_down_timer #(
    parameter int unsigned      Width      = 8,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [Width-1:0] value,
    output logic             expired
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= ResetValue;
        end else if (load) begin
            count_q <= value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/sensor_request_scheduler.sv
// Schedules DHT11 reads from one-shot commands and a periodic source, with read spacing,
// per-read timeout and a valid/ready response channel.
module sensor_request_scheduler
    import sensor_sched_pkg::*;
#(
    parameter int unsigned GAP_CYCLES     = 100000000,
    parameter int unsigned TIMEOUT_CYCLES = 250000000,
    parameter int unsigned PERIOD_CYCLES  = 500000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_code,
    input  logic       cmd_cont,
    output logic [1:0] sen_request,
    input  logic [7:0] sen_info,
    input  logic       sen_done,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_code,
    output logic [1:0] rsp_status,
    output logic       cont_active
);

    localparam int unsigned CntW = $clog2(max3(GAP_CYCLES, TIMEOUT_CYCLES, PERIOD_CYCLES) + 1);
    localparam logic [CntW-1:0] GapLoad = CntW'(GAP_CYCLES);
    // Timeout and period reload one less so the event lands exactly N edges after the load.
    localparam logic [CntW-1:0] TmoLoad = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] PerLoad = CntW'(PERIOD_CYCLES - 1);

    sched_state_e state_q;
    logic         ready_en_q;
    logic         slot_full_q;
    logic [1:0]   slot_code_q;
    logic [1:0]   cont_code_q;
    logic         per_pend_q;
    logic [1:0]   cur_code_q;

    logic gap_expired, tmo_expired, per_expired;
    logic cmd_fire, cmd_is_stop, start_cont, stop_cont, per_load;
    logic select, sel_slot, sel_per, done_evt, tmo_evt;
    logic [1:0] next_code;

    assign cmd_ready   = ready_en_q & ~slot_full_q;
    assign cmd_fire    = cmd_valid & cmd_ready;
    assign cmd_is_stop = (cmd_code == REQ_IDLE);
    assign start_cont  = cmd_fire & ~cmd_is_stop & cmd_cont;
    assign stop_cont   = cmd_fire & cmd_is_stop;
    assign per_load    = start_cont | (cont_active & per_expired);

    assign select    = (state_q == StIdle) & gap_expired & (slot_full_q | per_pend_q);
    assign sel_slot  = select & slot_full_q;
    assign sel_per   = select & ~slot_full_q;
    assign next_code = slot_full_q ? slot_code_q : cont_code_q;
    assign done_evt  = (state_q == StWait) & sen_done;
    assign tmo_evt   = ((state_q == StIssue) | (state_q == StWait)) & tmo_expired & ~done_evt;

    sched_down_timer #(.Width(CntW), .ResetValue(GapLoad)) u_gap_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (done_evt | tmo_evt),
        .value   (GapLoad),
        .expired (gap_expired)
    );

    sched_down_timer #(.Width(CntW), .ResetValue('0)) u_tmo_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (select),
        .value   (TmoLoad),
        .expired (tmo_expired)
    );

    sched_down_timer #(.Width(CntW), .ResetValue('0)) u_per_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (per_load),
        .value   (PerLoad),
        .expired (per_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_en_q  <= 1'b0;
            slot_full_q <= 1'b0;
            slot_code_q <= REQ_HUM;
        end else begin
            ready_en_q <= 1'b1;
            if (cmd_fire && !cmd_is_stop) begin
                slot_full_q <= 1'b1;
                slot_code_q <= cmd_code;
            end else if (sel_slot) begin
                slot_full_q <= 1'b0;
            end
        end
    end

    // A stop wins over everything; expiries coalesce into a single pending read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cont_active <= 1'b0;
            cont_code_q <= REQ_HUM;
            per_pend_q  <= 1'b0;
        end else if (stop_cont) begin
            cont_active <= 1'b0;
            per_pend_q  <= 1'b0;
        end else if (start_cont) begin
            cont_active <= 1'b1;
            cont_code_q <= cmd_code;
            per_pend_q  <= 1'b1;
        end else if (cont_active && per_expired) begin
            per_pend_q <= 1'b1;
        end else if (sel_per) begin
            per_pend_q <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cur_code_q  <= REQ_HUM;
            sen_request <= REQ_IDLE;
            rsp_valid   <= 1'b0;
            rsp_data    <= 8'h00;
            rsp_code    <= REQ_HUM;
            rsp_status  <= ST_OK;
        end else begin
            case (state_q)
                StIdle: begin
                    if (select) begin
                        cur_code_q  <= next_code;
                        sen_request <= next_code;
                        state_q     <= StIssue;
                    end
                end
                StIssue, StWait: begin
                    if (done_evt) begin
                        sen_request <= REQ_IDLE;
                        rsp_data    <= sen_info;
                        rsp_status  <= ST_OK;
                        rsp_code    <= cur_code_q;
                        rsp_valid   <= 1'b1;
                        state_q     <= StResp;
                    end else if (tmo_evt) begin
                        sen_request <= REQ_IDLE;
                        rsp_data    <= 8'hFF;
                        rsp_status  <= ST_TIMEOUT;
                        rsp_code    <= cur_code_q;
                        rsp_valid   <= 1'b1;
                        state_q     <= StResp;
                    end else if (state_q == StIssue && !sen_done) begin
                        // Done must be seen low first so a stale level from the last read is ignored.
                        state_q <= StWait;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_request_scheduler.sv
// Directed bench for sensor_request_scheduler with a behavioural DHT11 read FSM model.
module tb_sensor_request_scheduler;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_code = 2'b00;
    logic       cmd_cont = 1'b0;
    logic [1:0] sen_request;
    logic [7:0] sen_info = 8'h00;
    logic       sen_done = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [1:0] rsp_code;
    logic [1:0] rsp_status;
    logic       cont_active;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rel = 0;
    int scnt = 0;
    logic       mute = 1'b0;
    logic [7:0] sensor_val = 8'h00;

    sensor_request_scheduler #(
        .GAP_CYCLES     (20),
        .TIMEOUT_CYCLES (100),
        .PERIOD_CYCLES  (300)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_code    (cmd_code),
        .cmd_cont    (cmd_cont),
        .sen_request (sen_request),
        .sen_info    (sen_info),
        .sen_done    (sen_done),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_code    (rsp_code),
        .rsp_status  (rsp_status),
        .cont_active (cont_active)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Sensor: done drops 1 cycle after the request appears, rises 30 cycles after it.
    always @(posedge clock) begin
        if (sen_request == 2'b11) begin
            scnt <= 0;
        end else begin
            scnt <= scnt + 1;
            if (scnt == 0) sen_done <= 1'b0;
            if (scnt == 29 && !mute) begin
                sen_done <= 1'b1;
                sen_info <= sensor_val;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] code, input logic cont);
        bit ok;
        ok = 1'b0;
        cmd_code  = code;
        cmd_cont  = cont;
        cmd_valid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (cmd_ready) ok = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL cmd_handshake: cmd_ready stayed 0, required 1");
        end
    endtask

    task automatic wait_issue(output int t);
        t = -1;
        for (int i = 0; i < 1000 && t < 0; i++) begin
            if (sen_request !== 2'b11) t = cyc;
            else step();
        end
        if (t < 0) begin
            total++; bad++;
            $display("FAIL issue_wait: sen_request stayed 11, required an issue");
        end
    endtask

    task automatic wait_done(output int t);
        t = -1;
        step();
        step();
        for (int i = 0; i < 300 && t < 0; i++) begin
            if (sen_done === 1'b1) t = cyc;
            else step();
        end
        if (t < 0) begin
            total++; bad++;
            $display("FAIL done_wait: sen_done stayed 0, required 1");
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        total++;
        if (sen_request !== 2'b11) begin bad++; $display("FAIL reset_req: got %b, want 11", sen_request); end
        total++;
        if ({rsp_valid, rsp_data, rsp_code, rsp_status, cont_active} !== 14'h0) begin
            bad++;
            $display("FAIL reset_rsp: got v=%b d=%h c=%b s=%b ca=%b, want all zero",
                     rsp_valid, rsp_data, rsp_code, rsp_status, cont_active);
        end
        reset_n = 1'b1;
        rel = cyc;
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0: got %b, want 0", cmd_ready); end
        step();
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready1: got %b, want 1", cmd_ready); end
    endtask

    task automatic test_oneshot();
        int t, d;
        sensor_val = 8'h19;
        send_cmd(2'b01, 1'b0);
        wait_issue(t);
        total++;
        if (t - rel < 20) begin bad++; $display("FAIL first_issue: got %0d cycles, want >=20", t - rel); end
        total++;
        if (sen_request !== 2'b01) begin bad++; $display("FAIL oneshot_req: got %b, want 01", sen_request); end
        wait_done(d);
        step();
        total++;
        if (sen_request !== 2'b11) begin bad++; $display("FAIL oneshot_release: got %b, want 11", sen_request); end
        total++;
        if ({rsp_valid, rsp_data, rsp_code, rsp_status} !== {1'b1, 8'h19, 2'b01, 2'b00}) begin
            bad++;
            $display("FAIL oneshot_rsp: got v=%b d=%h c=%b s=%b, want 1/19/01/00",
                     rsp_valid, rsp_data, rsp_code, rsp_status);
        end
        consume();
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL oneshot_consume: got %b, want 0", rsp_valid); end
    endtask

    task automatic test_timeout();
        int t, a;
        mute = 1'b1;
        send_cmd(2'b00, 1'b0);
        wait_issue(t);
        a = -1;
        for (int i = 0; i < 200 && a < 0; i++) begin
            step();
            if (sen_request === 2'b11) a = cyc;
        end
        total++;
        if (a - t != 100) begin bad++; $display("FAIL timeout_time: got %0d, want 100", a - t); end
        total++;
        if ({rsp_valid, rsp_data, rsp_code, rsp_status} !== {1'b1, 8'hFF, 2'b00, 2'b01}) begin
            bad++;
            $display("FAIL timeout_rsp: got v=%b d=%h c=%b s=%b, want 1/ff/00/01",
                     rsp_valid, rsp_data, rsp_code, rsp_status);
        end
        consume();
        mute = 1'b0;
    endtask

    task automatic test_spacing();
        int d, t2;
        sensor_val = 8'hA1;
        send_cmd(2'b00, 1'b0);
        send_cmd(2'b01, 1'b0);
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("FAIL slot_full_ready: got %b, want 0", cmd_ready); end
        total++;
        if (sen_request !== 2'b00) begin bad++; $display("FAIL spacing_first: got %b, want 00", sen_request); end
        wait_done(d);
        sensor_val = 8'hB2;
        step();
        total++;
        if (rsp_data !== 8'hA1) begin bad++; $display("FAIL spacing_rsp1: got %h, want a1", rsp_data); end
        consume();
        wait_issue(t2);
        total++;
        if (t2 - d < 20) begin bad++; $display("FAIL spacing_gap: got %0d, want >=20", t2 - d); end
        total++;
        if (sen_request !== 2'b01) begin bad++; $display("FAIL spacing_second: got %b, want 01", sen_request); end
        wait_done(d);
        step();
        total++;
        if (rsp_data !== 8'hB2 || rsp_code !== 2'b01) begin
            bad++;
            $display("FAIL spacing_rsp2: got %h/%b, want b2/01", rsp_data, rsp_code);
        end
        consume();
    endtask

    task automatic test_continuous();
        int h, t, d;
        bit quiet;
        sensor_val = 8'h37;
        send_cmd(2'b00, 1'b1);
        h = cyc;
        total++;
        if (cont_active !== 1'b1) begin bad++; $display("FAIL cont_start: got %b, want 1", cont_active); end
        wait_issue(t);
        total++;
        if (sen_request !== 2'b00) begin bad++; $display("FAIL cont_first: got %b, want 00", sen_request); end
        wait_done(d);
        step();
        total++;
        if (rsp_data !== 8'h37) begin bad++; $display("FAIL cont_rsp1: got %h, want 37", rsp_data); end
        sensor_val = 8'hFF;
        send_cmd(2'b10, 1'b0);
        quiet = 1'b1;
        while (cyc < h + 700) begin
            if (sen_request !== 2'b11) quiet = 1'b0;
            step();
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL cont_bp_issue: got an issue, want none"); end
        consume();
        wait_issue(t);
        total++;
        if (sen_request !== 2'b10) begin bad++; $display("FAIL cont_oneshot_first: got %b, want 10", sen_request); end
        wait_done(d);
        sensor_val = 8'h38;
        step();
        total++;
        if ({rsp_data, rsp_code, rsp_status} !== {8'hFF, 2'b10, 2'b00}) begin
            bad++;
            $display("FAIL cont_stat_rsp: got %h/%b/%b, want ff/10/00", rsp_data, rsp_code, rsp_status);
        end
        consume();
        wait_issue(t);
        total++;
        if (sen_request !== 2'b00) begin bad++; $display("FAIL cont_periodic: got %b, want 00", sen_request); end
        wait_done(d);
        step();
        total++;
        if (rsp_data !== 8'h38) begin bad++; $display("FAIL cont_rsp2: got %h, want 38", rsp_data); end
        consume();
        sensor_val = 8'h39;
        wait_issue(t);
        total++;
        if (t - h < 850) begin bad++; $display("FAIL cont_coalesce: got issue at +%0d, want >=+850", t - h); end
        send_cmd(2'b11, 1'b0);
        total++;
        if (cont_active !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL cont_stop: got ca=%b v=%b, want 0/0", cont_active, rsp_valid);
        end
        wait_done(d);
        step();
        total++;
        if (rsp_data !== 8'h39) begin bad++; $display("FAIL cont_rsp3: got %h, want 39", rsp_data); end
        consume();
        quiet = 1'b1;
        repeat (450) begin
            if (sen_request !== 2'b11 || rsp_valid !== 1'b0) quiet = 1'b0;
            step();
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL cont_after_stop: got activity, want none"); end
    endtask

    task automatic test_backpressure();
        int t, d;
        bit stable;
        sensor_val = 8'h5A;
        send_cmd(2'b01, 1'b0);
        wait_issue(t);
        wait_done(d);
        step();
        sensor_val = 8'h66;
        send_cmd(2'b00, 1'b0);
        stable = 1'b1;
        repeat (50) begin
            if ({rsp_valid, rsp_data, rsp_code, rsp_status, sen_request} !==
                {1'b1, 8'h5A, 2'b01, 2'b00, 2'b11}) stable = 1'b0;
            step();
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL bp_stable: got v=%b d=%h c=%b s=%b req=%b, want 1/5a/01/00/11",
                     rsp_valid, rsp_data, rsp_code, rsp_status, sen_request);
        end
        consume();
        wait_issue(t);
        total++;
        if (sen_request !== 2'b00) begin bad++; $display("FAIL bp_next: got %b, want 00", sen_request); end
        wait_done(d);
        step();
        total++;
        if (rsp_data !== 8'h66) begin bad++; $display("FAIL bp_rsp2: got %h, want 66", rsp_data); end
        consume();
    endtask

    task automatic test_reset_mid_wait();
        int t;
        send_cmd(2'b00, 1'b1);
        wait_issue(t);
        repeat (10) step();
        reset_n = 1'b0;
        #1;
        total++;
        if ({sen_request, rsp_valid, cont_active} !== {2'b11, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_wait: got req=%b v=%b ca=%b, want 11/0/0",
                     sen_request, rsp_valid, cont_active);
        end
        repeat (2) step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_timeout();
        test_spacing();
        test_continuous();
        test_backpressure();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
